// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage -- ID/EX pipeline register with valid/ready flow control.
//
// Captures the decoded instruction (PC, register indices, operand data,
// immediate and control byte) into the EX slot. It supports back-pressure
// from EX, flushing and bubble insertion, and keeps a saturating count of
// back-pressure cycles.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_ready depends only on the EX slot state and out_ready. It
// never depends on in_valid, so there is no combinational loop back to
// decode. The EX slot holds its contents, unchanged, until out_ready is
// seen high.
//
// Optional feature: define ID_EX_WB_BYPASS_EN to forward the writeback
// port (wb_we/wb_rd/wb_data) into the operand data. Forwarding applies at
// load time and also while the slot is held. Without the macro the
// writeback port is ignored.
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   in_valid / in_ready     decode-side handshake
//   in_pc .. in_ctrl        decoded instruction fields
//   wb_we, wb_rd, wb_data   writeback port (used only with bypass enabled)
//   flush                   kill held and incoming instruction
//   out_valid / out_ready   EX-side handshake
//   out_pc .. out_ctrl      registered instruction fields (ctrl=0 when !valid)
//   stall_cnt               saturating count of out_valid && !out_ready cycles
// ---------------------------------------------------------------------------
module id_ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_pc,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [4:0]  in_rd,
  input  logic [63:0] in_rdata1,
  input  logic [63:0] in_rdata2,
  input  logic [63:0] in_imm,
  input  logic [7:0]  in_ctrl,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [63:0] wb_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [63:0] out_rdata1,
  output logic [63:0] out_rdata2,
  output logic [63:0] out_imm,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [4:0]  out_rd,
  output logic [7:0]  out_ctrl,
  output logic [15:0] stall_cnt
);

  logic        valid_q, valid_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] rdata1_q, rdata1_d;
  logic [63:0] rdata2_q, rdata2_d;
  logic [63:0] imm_q, imm_d;
  logic [4:0]  rs1_q, rs1_d;
  logic [4:0]  rs2_q, rs2_d;
  logic [4:0]  rd_q, rd_d;
  logic [7:0]  ctrl_q, ctrl_d;
  logic [15:0] stall_q, stall_d;

  // Operand values that would be captured on a load.
  logic [63:0] ld_rdata1, ld_rdata2;

  assign in_ready = !valid_q || out_ready;

`ifdef ID_EX_WB_BYPASS_EN
  logic byp_ld1, byp_ld2, byp_hold1, byp_hold2;
  // wb_rd != 0 keeps x0 from ever being forwarded.
  assign byp_ld1   = wb_we && (wb_rd != 5'd0) && (wb_rd == in_rs1);
  assign byp_ld2   = wb_we && (wb_rd != 5'd0) && (wb_rd == in_rs2);
  assign byp_hold1 = wb_we && (wb_rd != 5'd0) && (wb_rd == rs1_q);
  assign byp_hold2 = wb_we && (wb_rd != 5'd0) && (wb_rd == rs2_q);
  assign ld_rdata1 = (in_rs1 == 5'd0) ? 64'd0 : (byp_ld1 ? wb_data : in_rdata1);
  assign ld_rdata2 = (in_rs2 == 5'd0) ? 64'd0 : (byp_ld2 ? wb_data : in_rdata2);
`else
  logic unused_wb;
  assign unused_wb = ^{wb_we, wb_rd, wb_data};
  assign ld_rdata1 = (in_rs1 == 5'd0) ? 64'd0 : in_rdata1;
  assign ld_rdata2 = (in_rs2 == 5'd0) ? 64'd0 : in_rdata2;
`endif

  always_comb begin
    valid_d  = valid_q;
    pc_d     = pc_q;
    rdata1_d = rdata1_q;
    rdata2_d = rdata2_q;
    imm_d    = imm_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    rd_d     = rd_q;
    ctrl_d   = ctrl_q;
    stall_d  = stall_q;

    // Every back-pressured cycle counts, including one that is also flushed.
    if (valid_q && !out_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end

    if (flush) begin
      // Flush beats both load and hold. Only the valid bit and the control
      // byte need clearing; the data fields are don't-care while invalid.
      valid_d = 1'b0;
      ctrl_d  = 8'd0;
    end else if (in_ready) begin
      if (in_valid) begin
        valid_d  = 1'b1;
        pc_d     = in_pc;
        rdata1_d = ld_rdata1;
        rdata2_d = ld_rdata2;
        imm_d    = in_imm;
        rs1_d    = in_rs1;
        rs2_d    = in_rs2;
        rd_d     = in_rd;
        ctrl_d   = in_ctrl;
      end else begin
        valid_d = 1'b0;
        ctrl_d  = 8'd0;
      end
    end else begin
      // Hold. With bypass enabled, a register written back while the slot
      // is stalled is refreshed in place, so EX never uses a stale operand.
`ifdef ID_EX_WB_BYPASS_EN
      if (byp_hold1) rdata1_d = wb_data;
      if (byp_hold2) rdata2_d = wb_data;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      pc_q     <= 64'd0;
      rdata1_q <= 64'd0;
      rdata2_q <= 64'd0;
      imm_q    <= 64'd0;
      rs1_q    <= 5'd0;
      rs2_q    <= 5'd0;
      rd_q     <= 5'd0;
      ctrl_q   <= 8'd0;
      stall_q  <= 16'd0;
    end else begin
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
      imm_q    <= imm_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      rd_q     <= rd_d;
      ctrl_q   <= ctrl_d;
      stall_q  <= stall_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_pc     = pc_q;
  assign out_rdata1 = rdata1_q;
  assign out_rdata2 = rdata2_q;
  assign out_imm    = imm_q;
  assign out_rs1    = rs1_q;
  assign out_rs2    = rs2_q;
  assign out_rd     = rd_q;
  assign out_ctrl   = ctrl_q;
  assign stall_cnt  = stall_q;

endmodule
